// File: rtl/noc_port_arbiter.sv
// Per-output-port wormhole arbiter: round-robin grant held from head flit to tail flit.
// Optional stall watchdog enabled by defining NOC_ARB_TIMEOUT_EN.
module noc_port_arbiter #(
    parameter int NUM_REQ    = 5,
    parameter int IDX_W      = 3,
    parameter int HOLD_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] tail,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               xfer,
    output logic               timeout
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    if (HOLD_LIMIT < 2 || HOLD_LIMIT > 255) begin : g_bad_hold_limit
        $error("HOLD_LIMIT out of range 2..255");
    end
    if ((1 << IDX_W) < NUM_REQ) begin : g_bad_idx_w
        $error("IDX_W too narrow for NUM_REQ");
    end

    // First requester found searching upward from ptr+1 with wrap-around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        int   pos;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && r[pos]) begin
                rr_pick = IDX_W'(pos);
                found   = 1'b1;
            end
        end
    endfunction

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic               grant_valid_r;
    logic [IDX_W-1:0]   grant_idx_r, grant_idx_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               req_hit_s;
    logic               tail_hit_s;
    logic               xfer_s;
    logic               release_s;
    logic               watchdog_fire_s;

    // Grant is one-hot, so masking req/tail with it samples only the granted input.
    assign req_hit_s  = |(grant_r & req);
    assign tail_hit_s = |(grant_r & tail);
    assign xfer_s     = req_hit_s & out_ready;
    assign sel_idx_s  = rr_pick(req, rr_ptr_r);

`ifdef NOC_ARB_TIMEOUT_EN
    logic [7:0] stall_cnt_r, stall_cnt_s;
    logic       timeout_r;

    assign watchdog_fire_s = (state_r == ST_LOCKED) && (stall_cnt_r >= 8'(HOLD_LIMIT));

    // Stall counter next value: clears on transfer or release, counts starved locked cycles.
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (state_r != ST_LOCKED || release_s || xfer_s) begin
            stall_cnt_s = 8'd0;
        end else if (!req_hit_s) begin
            stall_cnt_s = stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // Watchdog state and one-cycle timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 8'd0;
            timeout_r   <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_s;
            timeout_r   <= watchdog_fire_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign watchdog_fire_s = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, hold grant in LOCKED until tail or watchdog.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        rr_ptr_s    = rr_ptr_r;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_s     = ONE_HOT_0 << sel_idx_s;
                    grant_idx_s = sel_idx_s;
                    state_s     = ST_LOCKED;
                end else begin
                    grant_s     = '0;
                    grant_idx_s = '0;
                end
            end
            ST_LOCKED: begin
                if (watchdog_fire_s || (xfer_s && tail_hit_s)) begin
                    release_s   = 1'b1;
                    grant_s     = '0;
                    grant_idx_s = '0;
                    rr_ptr_s    = grant_idx_r;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                grant_s     = '0;
                grant_idx_s = '0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_idx_r   <= '0;
            rr_ptr_r      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            grant_valid_r <= |grant_s;
            grant_idx_r   <= grant_idx_s;
            rr_ptr_r      <= rr_ptr_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;
    assign xfer        = xfer_s;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a packet-level reference model.
module tb_noc_port_arbiter;

    localparam int NUM = 5;
`ifdef NOC_ARB_TIMEOUT_EN
    localparam int HL = 4;
`else
    localparam int HL = 16;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NUM-1:0] req;
    logic [NUM-1:0] tail;
    logic           out_ready;
    logic [NUM-1:0] grant;
    logic           grant_valid;
    logic [2:0]     grant_idx;
    logic           xfer;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    noc_port_arbiter #(.NUM_REQ(NUM), .IDX_W(3), .HOLD_LIMIT(HL)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .xfer(xfer), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: who owns the link, who was served last, stall count.
    bit m_locked;
    int m_owner;
    int m_last;
    int m_cnt;
    bit m_tout;

    function automatic int pick(input logic [NUM-1:0] r, input int last);
        for (int k = 1; k <= NUM; k++) begin
            int i;
            i = (last + k) % NUM;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_last   <= NUM - 1;
            m_cnt    <= 0;
            m_tout   <= 1'b0;
        end else if (!m_locked) begin
            m_tout <= 1'b0;
            m_cnt  <= 0;
            if (req != '0) begin
                m_locked <= 1'b1;
                m_owner  <= pick(req, m_last);
            end
        end else begin
            m_tout <= 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
            if (m_cnt >= HL) begin
                m_locked <= 1'b0;
                m_last   <= m_owner;
                m_cnt    <= 0;
                m_tout   <= 1'b1;
            end else
`endif
            if (req[m_owner] && out_ready && tail[m_owner]) begin
                m_locked <= 1'b0;
                m_last   <= m_owner;
                m_cnt    <= 0;
            end else if (req[m_owner] && out_ready) begin
                m_cnt <= 0;
            end else if (!req[m_owner]) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NUM-1:0] e_grant;
        e_grant = m_locked ? (NUM'(1) << m_owner) : '0;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("grant_valid", 32'(grant_valid), 32'(m_locked));
        chk("grant_idx", 32'(grant_idx), m_locked ? 32'(m_owner) : 32'd0);
        chk("xfer", 32'(xfer), 32'(m_locked && req[m_owner] && out_ready));
        chk("timeout", 32'(timeout), 32'(m_tout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // 3-flit packet from L
        rst = 1'b0; req = 5'b10000; tail = 5'b00000; out_ready = 1'b1;
        #1 chk("l_latency", 32'(grant), 32'd0);
        tick(); #1;
        chk("l_grant", 32'(grant), 32'b10000);
        chk("l_idx", 32'(grant_idx), 32'd4);
        chk("l_xfer1", 32'(xfer), 32'd1);
        tick(); #1 chk("l_xfer2", 32'(xfer), 32'd1);
        tick(); tail = 5'b10000;
        #1 chk("l_xfer3", 32'(xfer), 32'd1);
        tick(); req = '0; tail = '0;
        #1 chk("l_release", 32'(grant_valid), 32'd0);

        // all requesting single-flit packets: 0,1,2,3,4,0
        req = 5'b11111; tail = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk("rr_idx", 32'(grant_idx), 32'(k % NUM));
            chk("rr_valid", 32'(grant_valid), 32'd1);
            tick(); #1;
            chk("rr_bubble", 32'(grant_valid), 32'd0);
        end
        req = '0; tail = '0;

        // lock on E, competitor arrives, E bubbles for 3 cycles
        tick();
        req = 5'b00100; tail = 5'b00000;
        tick(); #1 chk("e_grant", 32'(grant), 32'b00100);
        req = 5'b00101;
        tick(); #1 chk("e_hold", 32'(grant), 32'b00100);
        req = 5'b00001;
        repeat (3) begin
            #1;
            chk("e_bubble_grant", 32'(grant), 32'b00100);
            chk("e_bubble_xfer", 32'(xfer), 32'd0);
            tick();
        end
        req = 5'b00101; tail = 5'b00100;
        #1 chk("e_tail_xfer", 32'(xfer), 32'd1);
        tick(); #1 chk("e_released", 32'(grant_valid), 32'd0);
        tick(); #1 chk("n_after_e", 32'(grant), 32'b00001);
        tail = 5'b00001;
        tick(); req = '0; tail = '0;
        tick();

        // W held under back-pressure
        req = 5'b01000; tail = 5'b00000; out_ready = 1'b0;
        tick(); #1;
        chk("w_grant", 32'(grant), 32'b01000);
        chk("w_noxfer", 32'(xfer), 32'd0);
        repeat (10) begin
            tick(); #1;
            chk("w_hold", 32'(grant), 32'b01000);
            chk("w_stall", 32'(xfer), 32'd0);
        end
        out_ready = 1'b1; tail = 5'b01000;
        #1 chk("w_tail_xfer", 32'(xfer), 32'd1);
        tick(); #1 chk("w_released", 32'(grant_valid), 32'd0);
        req = '0; tail = '0;
        tick();

        // asynchronous reset mid-packet on S
        req = 5'b00010;
        tick(); #1 chk("s_grant", 32'(grant), 32'b00010);
        tick();
        rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_valid", 32'(grant_valid), 32'd0);
        chk("async_idx", 32'(grant_idx), 32'd0);
        tick();
        rst = 1'b0; req = 5'b00011;
        tick(); #1 chk("post_rst_grant", 32'(grant), 32'b00001);
        tail = 5'b00001;
        tick(); req = '0; tail = '0;
        tick();

        // starved grant on S
        req = 5'b00010; tail = 5'b00000;
        tick(); #1 chk("wd_grant", 32'(grant), 32'b00010);
        req = 5'b00100;
`ifdef NOC_ARB_TIMEOUT_EN
        repeat (4) tick();
        #1;
        chk("wd_before", 32'(grant), 32'b00010);
        chk("wd_no_pulse", 32'(timeout), 32'd0);
        tick(); #1;
        chk("wd_release", 32'(grant_valid), 32'd0);
        chk("wd_pulse", 32'(timeout), 32'd1);
        tick(); #1;
        chk("wd_next", 32'(grant), 32'b00100);
        chk("wd_pulse_end", 32'(timeout), 32'd0);
        tail = 5'b00100;
        tick();
`else
        repeat (20) tick();
        #1;
        chk("wd_held", 32'(grant), 32'b00010);
        chk("wd_no_timeout", 32'(timeout), 32'd0);
        req = 5'b00010; tail = 5'b00010;
        tick();
`endif
        req = '0; tail = '0;
        tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            tail      = NUM'($urandom) & NUM'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; req = '0; tail = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Per-output-port wormhole arbiter for the mesh router.
- Up to NUM_REQ input ports (N, S, E, W, L) compete for one output link.
- Grants one requester with fair round-robin and holds the grant for the whole packet, head flit through tail flit.
- One instance sits in front of each output ifc send port. The crossbar mux select is driven from grant_idx.

Parameters:
- NUM_REQ, 5: number of requesting input ports. Index order: 0=N, 1=S, 2=E, 3=W, 4=L.
- IDX_W, 3: width of grant_idx. Must be at least clog2(NUM_REQ).
- HOLD_LIMIT, 16: stall-cycle limit for the optional watchdog. Range 2..255.

Ports:
- clk  in  1  router clock (control.clk)
- rst  in  1  asynchronous, active-high reset (control.rst)
- req  in  NUM_REQ  input i has a valid flit routed to this output
- tail  in  NUM_REQ  flit currently presented by input i is a tail flit (single-flit packet: head and tail together)
- out_ready  in  1  downstream link/buffer accepts a flit this cycle
- grant  out  NUM_REQ  one-hot grant, registered
- grant_valid  out  1  OR of grant
- grant_idx  out  IDX_W  binary index of granted input; 0 when none
- xfer  out  1  combinational: grant_valid & req[grant_idx] & out_ready
- timeout  out  1  one-cycle pulse when the watchdog force-releases a grant

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - state=IDLE.
  - rr_ptr=NUM_REQ-1, so input 0 has highest priority first.
  - Watchdog counter=0.
  - Reset asserted mid-packet drops the grant immediately. No flit is counted as transferred.
- State IDLE:
  - If req!=0, select the first set bit searching upward from (rr_ptr+1) mod NUM_REQ, with wrap-around.
  - Next edge: grant=onehot(sel), grant_idx=sel, state=LOCKED.
  - If req=0, stay in IDLE with outputs at 0.
  - Arbitration latency: 1 cycle from req to grant.
- State LOCKED:
  - Grant is held constant regardless of other req bits.
  - Deassertion of req[grant_idx] (input bubble) does not release the grant.
  - A transfer occurs on any cycle where xfer=1.
  - Transfer with tail[grant_idx]=1: next edge grant=0, rr_ptr=grant_idx, state=IDLE.
  - Re-arbitration occurs in that IDLE cycle. There is therefore exactly one idle bubble between packets on a port. This is accepted.
  - Transfer without tail: stay in LOCKED.
  - out_ready=0: no transfer; state and grant are unchanged.
- Fairness:
  - The last-served input gets the lowest priority in the next round.
  - With all NUM_REQ inputs continuously requesting, each is granted once per NUM_REQ packets.
- Bit-masking rules:
  - tail is only sampled for the granted index.
  - req/tail bits at index >= NUM_REQ do not exist.
  - A set tail bit without its req bit is ignored.
- Single-flit packet: grant cycle plus transfer cycle; released on the following edge.

Optional Feature:
- Macro: NOC_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter counts LOCKED cycles where req[grant_idx]=0, i.e. the input is stalled.
  - It clears on any xfer and on leaving LOCKED.
  - When the count reaches HOLD_LIMIT, on the next edge: grant is released, state=IDLE, rr_ptr=grant_idx, timeout pulses high for 1 cycle, counter=0.
- Undefined: no counter is instantiated; timeout is tied to 0; the grant is held indefinitely until the tail flit.

Test Plan:
- Reset then req=5'b10000 (L), 3-flit packet with out_ready=1, tail on the 3rd flit -> grant=5'b10000 one cycle after req, xfer high for 3 cycles, grant=0 the cycle after the tail, rr_ptr=4.
- req=5'b11111 held, single-flit packets, tail=5'b11111 -> grants in order 0,1,2,3,4,0, one every 2 cycles.
- Lock on input 2 (E), raise req[0] mid-packet, drop req[2] for 3 cycles, resume -> grant stays 5'b00100 until the E tail; then input 0 is granted.
- Grant held on input 3 with out_ready=0 for 10 cycles -> no xfer, grant unchanged; tail transfers when out_ready=1.
- Assert rst while locked on input 1 mid-packet -> grant=0 immediately (same cycle, asynchronous); after release, req=5'b00011 grants input 0 first.
- With NOC_ARB_TIMEOUT_EN and HOLD_LIMIT=4: lock input 1, then req[1]=0 -> timeout pulses after 4 stall cycles, grant released, next grant goes to another requester. Without the macro: grant held and timeout stays 0.
